// File: rtl/adc_conv_ctrl.sv
// Conversion sequencer for a parallel-bus ADC: periodic CONVST, BUSY handshake, CS/RD read strobes.
// Define ADC_AVG_EN to report the mean of every four captures instead of each raw capture.
module adc_conv_ctrl #(
    parameter int SAMPLE_DIV = 50000,
    parameter int CONVST_W   = 4,
    parameter int RD_W       = 3,
    parameter int TIMEOUT    = 255
) (
    input  logic        CLOCK_50,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        adc_busy,
    input  logic [11:0] adc_data,
    output logic        adc_convst_n,
    output logic        adc_cs_n,
    output logic        adc_rd_n,
    output logic [11:0] sample,
    output logic        sample_valid,
    output logic        timeout_err
);

    localparam int TICK_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int PH_MAX = (CONVST_W > RD_W) ? CONVST_W : RD_W;
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_DIV - 1);
    localparam logic [PH_W-1:0]   CONV_LAST = PH_W'(CONVST_W - 1);
    localparam logic [PH_W-1:0]   RD_LAST   = PH_W'(RD_W - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        CONV,
        WAIT_HI,
        WAIT_LO,
        READ,
        DONE
    } state_t;

    state_t            state;
    logic [TICK_W-1:0] tick_cnt;
    logic              tick;
    logic              busy_meta;
    logic              busy_sync;
    logic [PH_W-1:0]   phase_cnt;
    logic [WAIT_W-1:0] wait_cnt;

`ifdef ADC_AVG_EN
    logic [13:0] avg_sum;
    logic [1:0]  avg_cnt;
    logic [13:0] avg_next;

    assign avg_next = avg_sum + {2'b00, adc_data};
`endif

    assign tick = (tick_cnt == TICK_LAST);

    // Sample-rate timebase keeps running regardless of what the sequencer is doing.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            busy_meta <= 1'b0;
            busy_sync <= 1'b0;
        end else begin
            busy_meta <= adc_busy;
            busy_sync <= busy_meta;
        end
    end

    // The wait counter spans both BUSY phases so a stuck-high BUSY also times out.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            state        <= IDLE;
            phase_cnt    <= '0;
            wait_cnt     <= '0;
            adc_convst_n <= 1'b1;
            adc_cs_n     <= 1'b1;
            adc_rd_n     <= 1'b1;
            sample       <= '0;
            sample_valid <= 1'b0;
            timeout_err  <= 1'b0;
`ifdef ADC_AVG_EN
            avg_sum      <= '0;
            avg_cnt      <= '0;
`endif
        end else begin
            sample_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick && enable) begin
                        state        <= CONV;
                        phase_cnt    <= '0;
                        adc_convst_n <= 1'b0;
                    end
                end
                CONV: begin
                    if (phase_cnt == CONV_LAST) begin
                        adc_convst_n <= 1'b1;
                        wait_cnt     <= '0;
                        state        <= WAIT_HI;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                WAIT_HI: begin
                    if (wait_cnt == WAIT_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                        if (busy_sync) begin
                            state <= WAIT_LO;
                        end
                    end
                end
                WAIT_LO: begin
                    if (!busy_sync) begin
                        phase_cnt <= '0;
                        adc_cs_n  <= 1'b0;
                        adc_rd_n  <= 1'b0;
                        state     <= READ;
                    end else if (wait_cnt == WAIT_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                READ: begin
                    if (phase_cnt == RD_LAST) begin
                        adc_cs_n <= 1'b1;
                        adc_rd_n <= 1'b1;
                        state    <= DONE;
`ifdef ADC_AVG_EN
                        if (avg_cnt == 2'd3) begin
                            sample       <= avg_next[13:2];
                            sample_valid <= 1'b1;
                            avg_sum      <= '0;
                            avg_cnt      <= '0;
                        end else begin
                            avg_sum <= avg_next;
                            avg_cnt <= avg_cnt + 2'd1;
                        end
`else
                        sample       <= adc_data;
                        sample_valid <= 1'b1;
`endif
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_conv_ctrl.sv
// Scoreboard bench for adc_conv_ctrl with a behavioural ADC model; define ADC_AVG_EN to exercise averaging.
module tb_adc_conv_ctrl;

    localparam int SAMPLE_DIV = 100;
    localparam int CONVST_W   = 4;
    localparam int RD_W       = 3;
    localparam int TIMEOUT    = 255;

    logic        CLOCK_50 = 1'b0;
    logic        reset_n  = 1'b0;
    logic        enable   = 1'b0;
    logic        adc_busy = 1'b0;
    logic [11:0] adc_data = '0;
    logic        adc_convst_n;
    logic        adc_cs_n;
    logic        adc_rd_n;
    logic [11:0] sample;
    logic        sample_valid;
    logic        timeout_err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int valid_seen = 0;
    int conv_starts = 0;
    int reads_done = 0;
    int convst_rise_cyc = 0;
    int err_cyc = 0;
    int busy_len = 10;
    bit busy_never = 1'b0;
    logic [11:0] exp_q[$];
    logic [11:0] data_q[$];
    int valid_cyc[$];
    int start_cyc[$];

    adc_conv_ctrl #(
        .SAMPLE_DIV(SAMPLE_DIV),
        .CONVST_W  (CONVST_W),
        .RD_W      (RD_W),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .reset_n     (reset_n),
        .enable      (enable),
        .adc_busy    (adc_busy),
        .adc_data    (adc_data),
        .adc_convst_n(adc_convst_n),
        .adc_cs_n    (adc_cs_n),
        .adc_rd_n    (adc_rd_n),
        .sample      (sample),
        .sample_valid(sample_valid),
        .timeout_err (timeout_err)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) cyc = cyc + 1;

    always @(posedge timeout_err) err_cyc = cyc;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic [11:0] data, input int blen, input bit never);
        enable     = en;
        adc_data   = data;
        busy_len   = blen;
        busy_never = never;
    endtask

    task automatic boundFail(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s actual=timeout required=event", name);
    endtask

    task automatic waitValids(input int target, input int bound, input string name);
        int n = 0;
        while (valid_seen < target && n < bound) begin
            @(negedge CLOCK_50);
            n++;
        end
        if (valid_seen < target) boundFail(name);
    endtask

    task automatic doReset();
        int n = 0;
        while (adc_busy && n < 400) begin
            @(negedge CLOCK_50);
            n++;
        end
        reset_n = 1'b0;
        enable  = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        reset_n = 1'b1;
    endtask

    // Scoreboard monitor: every sample_valid pulse must match the oldest expectation.
    always @(negedge CLOCK_50) begin
        if (sample_valid) begin
            valid_seen++;
            valid_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_valid actual=%0h required=no_pulse", sample);
            end else begin
                checkOutput("scoreboard_sample", 32'(sample), 32'(exp_q.pop_front()));
            end
        end
    end

    // ADC model: BUSY rises one cycle after CONVST ends and stays high busy_len cycles.
    initial begin
        int t0;
        forever begin
            @(negedge adc_convst_n);
            conv_starts++;
            start_cyc.push_back(cyc);
            t0 = cyc;
            if (!busy_never && data_q.size() > 0) adc_data = data_q.pop_front();
            @(posedge adc_convst_n);
            convst_rise_cyc = cyc;
            if (reset_n) checkOutput("convst_width", 32'(cyc - t0), 32'(CONVST_W));
            if (!busy_never) begin
                @(negedge CLOCK_50);
                adc_busy = 1'b1;
                repeat (busy_len) @(negedge CLOCK_50);
                adc_busy = 1'b0;
            end
        end
    end

    initial begin
        int t0;
        forever begin
            @(negedge adc_cs_n);
            t0 = cyc;
            @(negedge CLOCK_50);
            checkOutput("rd_n_with_cs_n", 32'(adc_rd_n), 32'd0);
            @(posedge adc_cs_n);
            if (reset_n) begin
                reads_done++;
                checkOutput("read_width", 32'(cyc - t0), 32'(RD_W));
            end
        end
    end

    initial begin
        repeat (20000) @(posedge CLOCK_50);
        $display("[TB] FAIL watchdog actual=expired required=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        int base_v;
        int base_s;
        int r0;

        repeat (3) @(negedge CLOCK_50);
        checkOutput("reset_convst_n", 32'(adc_convst_n), 32'd1);
        checkOutput("reset_cs_n", 32'(adc_cs_n), 32'd1);
        checkOutput("reset_rd_n", 32'(adc_rd_n), 32'd1);
        checkOutput("reset_sample", 32'(sample), 32'd0);
        checkOutput("reset_valid", 32'(sample_valid), 32'd0);
        checkOutput("reset_timeout_err", 32'(timeout_err), 32'd0);
        reset_n = 1'b1;

`ifdef ADC_AVG_EN
        // Four captures averaged: (100+200+300+401)/4 = 250
        $display("[TB] averaging of four captures");
        data_q.push_back(12'd100);
        data_q.push_back(12'd200);
        data_q.push_back(12'd300);
        data_q.push_back(12'd401);
        exp_q.push_back(12'd250);
        base_v = valid_seen;
        applyStimulus(1'b1, 12'd0, 10, 1'b0);
        waitValids(base_v + 1, 700, "avg_wait_valid");

        // A timeout between captures must not count towards the group of four
        $display("[TB] timeout inside an averaging group");
        r0 = reads_done;
        data_q.push_back(12'd40);
        n = 0;
        while (reads_done < r0 + 1 && n < 300) begin
            @(negedge CLOCK_50);
            n++;
        end
        if (reads_done < r0 + 1) boundFail("avg_wait_read");
        busy_never = 1'b1;
        n = 0;
        while (!timeout_err && n < 500) begin
            @(negedge CLOCK_50);
            n++;
        end
        if (!timeout_err) boundFail("avg_wait_timeout");
        busy_never = 1'b0;
        data_q.push_back(12'd40);
        data_q.push_back(12'd40);
        data_q.push_back(12'd40);
        exp_q.push_back(12'd40);
        base_v = valid_seen;
        waitValids(base_v + 1, 600, "avg_after_timeout_valid");
        enable = 1'b0;
        checkOutput("avg_err_sticky", 32'(timeout_err), 32'd1);
        checkOutput("avg_drain", 32'(exp_q.size()), 32'd0);
`else
        // Steady conversions: one 12'hABC per tick period
        $display("[TB] periodic conversions");
        doReset();
        base_v = valid_seen;
        base_s = conv_starts;
        repeat (3) exp_q.push_back(12'hABC);
        applyStimulus(1'b1, 12'hABC, 10, 1'b0);
        waitValids(base_v + 3, 500, "periodic_wait_valid");
        enable = 1'b0;
        if (valid_cyc.size() >= 2)
            checkOutput("valid_period", 32'(valid_cyc[valid_cyc.size()-1] - valid_cyc[valid_cyc.size()-2]), 32'(SAMPLE_DIV));
        if (start_cyc.size() >= 2)
            checkOutput("start_period", 32'(start_cyc[start_cyc.size()-1] - start_cyc[start_cyc.size()-2]), 32'(SAMPLE_DIV));
        checkOutput("periodic_err", 32'(timeout_err), 32'd0);
        checkOutput("periodic_drain", 32'(exp_q.size()), 32'd0);

        // BUSY never rises: timeout after exactly TIMEOUT wait cycles
        $display("[TB] BUSY timeout");
        doReset();
        base_v = valid_seen;
        applyStimulus(1'b1, 12'hFFF, 10, 1'b1);
        n = 0;
        while (!timeout_err && n < 600) begin
            @(negedge CLOCK_50);
            n++;
        end
        if (!timeout_err) boundFail("timeout_wait_err");
        busy_never = 1'b0;
        checkOutput("timeout_cycles", 32'(err_cyc - convst_rise_cyc), 32'(TIMEOUT));
        checkOutput("timeout_no_valid", 32'(valid_seen - base_v), 32'd0);
        checkOutput("timeout_sample", 32'(sample), 32'd0);
        checkOutput("timeout_idle_strobes", 32'({adc_convst_n, adc_cs_n, adc_rd_n}), 32'd7);
        adc_data = 12'h321;
        exp_q.push_back(12'h321);
        waitValids(base_v + 1, 300, "after_timeout_valid");
        enable = 1'b0;
        checkOutput("timeout_err_sticky", 32'(timeout_err), 32'd1);

        // Enable dropped during WAIT_LO: this sample completes, no new CONVST
        $display("[TB] enable dropped mid-conversion");
        doReset();
        base_v = valid_seen;
        base_s = conv_starts;
        exp_q.push_back(12'h5A5);
        applyStimulus(1'b1, 12'h5A5, 10, 1'b0);
        n = 0;
        while (!adc_busy && n < 300) begin
            @(negedge CLOCK_50);
            n++;
        end
        if (!adc_busy) boundFail("drop_wait_busy");
        repeat (4) @(negedge CLOCK_50);
        enable = 1'b0;
        repeat (300) @(negedge CLOCK_50);
        checkOutput("drop_valid_count", 32'(valid_seen - base_v), 32'd1);
        checkOutput("drop_convst_count", 32'(conv_starts - base_s), 32'd1);

        // Reset during READ clears sample and releases strobes on the next edge
        $display("[TB] reset during READ");
        doReset();
        base_v = valid_seen;
        exp_q.push_back(12'h123);
        applyStimulus(1'b1, 12'h123, 10, 1'b0);
        waitValids(base_v + 1, 300, "read_reset_first_valid");
        adc_data = 12'h456;
        n = 0;
        while (adc_cs_n && n < 300) begin
            @(negedge CLOCK_50);
            n++;
        end
        if (adc_cs_n) boundFail("read_reset_wait_cs");
        reset_n = 1'b0;
        @(negedge CLOCK_50);
        checkOutput("rst_read_cs_n", 32'(adc_cs_n), 32'd1);
        checkOutput("rst_read_rd_n", 32'(adc_rd_n), 32'd1);
        checkOutput("rst_read_convst_n", 32'(adc_convst_n), 32'd1);
        checkOutput("rst_read_sample", 32'(sample), 32'd0);
        checkOutput("rst_read_valid", 32'(sample_valid), 32'd0);
        enable  = 1'b0;
        reset_n = 1'b1;
        repeat (10) @(negedge CLOCK_50);
        checkOutput("rst_read_no_valid", 32'(valid_seen - base_v), 32'd1);

        // Long BUSY: the tick during the conversion is dropped, not queued
        $display("[TB] long BUSY drops a tick");
        doReset();
        base_v = valid_seen;
        base_s = conv_starts;
        exp_q.push_back(12'h7E7);
        exp_q.push_back(12'h7E7);
        applyStimulus(1'b1, 12'h7E7, 150, 1'b0);
        waitValids(base_v + 2, 900, "long_busy_valid");
        enable = 1'b0;
        checkOutput("long_busy_starts", 32'(conv_starts - base_s), 32'd2);
        if (start_cyc.size() >= 2)
            checkOutput("long_busy_start_gap", 32'(start_cyc[start_cyc.size()-1] - start_cyc[start_cyc.size()-2]), 32'(2 * SAMPLE_DIV));
        checkOutput("long_busy_err", 32'(timeout_err), 32'd0);
        busy_len = 10;
        checkOutput("final_drain", 32'(exp_q.size()), 32'd0);
`endif

        repeat (5) @(negedge CLOCK_50);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
